// File: rtl/rom_arb_pkg.sv
// Shared definitions for the two-client ROM burst arbiter: default widths,
// FSM state encodings and the requester-id type.
package rom_arb_pkg;

    // Default ROM geometry: 16 words of 8 bits.
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

    // Controller states, kept as plain constants so older tools and
    // waveform scripts that expect raw encodings keep working.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BURST = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    // Identifies one of the two requesters.
    typedef logic rid_t;

    localparam rid_t RID0 = 1'b0;
    localparam rid_t RID1 = 1'b1;

    // One-hot grant vector for a given requester id.
    function automatic logic [1:0] onehot2(input rid_t id);
        logic [1:0] v;
        v = 2'b00;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. A lone requester always wins; when both ask,
// the one that was not served most recently wins.
module rr_arb2
    import rom_arb_pkg::*;
(
    input  logic [1:0] req,
    input  rid_t       last_served,
    output logic [1:0] grant,
    output rid_t       winner
);

    // Winner selection and one-hot grant, purely combinational.
    always_comb begin
        winner = RID0;
        grant  = 2'b00;
        if (req == 2'b11) begin
            winner = ~last_served;
        end else if (req[1]) begin
            winner = RID1;
        end else begin
            winner = RID0;
        end
        if (|req) begin
            grant = onehot2(winner);
        end
    end

endmodule

// File: rtl/rom_burst_arbiter.sv
// Shares one combinational ROM between two burst requesters. The granted
// requester's start address and length are captured at grant time and the
// words are streamed out through a registered valid/ready channel.
module rom_burst_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] len0,
    input  logic [ADDR_W-1:0] len1,
    output logic [1:0]        ack,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output rid_t              rd_id,
    output logic              rd_last,
    output logic              busy
);

    logic [1:0]        state;
    logic [1:0]        next_state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] cnt;
    rid_t              id;
    rid_t              last_served;
    logic [1:0]        grant;
    rid_t              winner;
    logic              grant_now;
    logic              load;
    logic              accept;
    logic              last_word;

    rr_arb2 u_arb (
        .req         (req),
        .last_served (last_served),
        .grant       (grant),
        .winner      (winner)
    );

    // A new burst is only granted from IDLE, which guarantees an idle cycle
    // between bursts and makes req changes mid-burst invisible.
    assign grant_now = (state == IDLE) && (|req);

    // The output register takes a new word when it is empty or its current
    // word leaves this cycle, so a steady rd_ready gives one word per cycle.
    assign accept    = rd_valid && rd_ready;
    assign load      = (state == BURST) && (!rd_valid || rd_ready);
    assign last_word = (cnt == '0);

    // The ROM is addressed straight from the burst pointer; outside BURST it
    // simply holds the pointer's last value.
    assign rom_addr = ptr;
    assign busy     = (state != IDLE);

    // Next-state decode for IDLE -> BURST -> DRAIN -> IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (grant_now) begin
                    next_state = BURST;
                end
            end
            BURST: begin
                if (load && last_word) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (accept) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register; reset abandons any burst in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Grant bookkeeping: one-cycle ack pulse, round-robin history and the
    // burst descriptor captured from the winner. last_served resets to 1 so
    // requester 0 wins the first contested grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack         <= 2'b00;
            last_served <= RID1;
            id          <= RID0;
            ptr         <= '0;
            cnt         <= '0;
        end else begin
            ack <= 2'b00;
            if (grant_now) begin
                ack         <= grant;
                last_served <= winner;
                id          <= winner;
                ptr         <= (winner == RID1) ? addr1 : addr0;
                cnt         <= (winner == RID1) ? len1  : len0;
            end else if (load) begin
                ptr <= ptr + 1'b1;
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Output beat register. Data, id and last only change on a load, so they
    // hold steady while the consumer stalls; DRAIN retires the final beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_id    <= RID0;
            rd_last  <= 1'b0;
        end else if (load) begin
            rd_valid <= 1'b1;
            rd_data  <= rom_data;
            rd_id    <= id;
            rd_last  <= last_word;
        end else if ((state == DRAIN) && accept) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Directed testbench for rom_burst_arbiter: a table of per-cycle vectors for
// reset, a plain burst and a wrapping burst, followed by hand-written
// sequences for backpressure, fairness and reset during a burst.
module tb_rom_burst_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [3:0] addr0;
    logic [3:0] addr1;
    logic [3:0] len0;
    logic [3:0] len1;
    logic [1:0] ack;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic       rd_id;
    logic       rd_last;
    logic       busy;

    logic [7:0] rom [16];

    int checks;
    int errors;

    logic [7:0] beatData [$];
    logic       beatId   [$];
    logic [1:0] ackSeq   [$];

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic [3:0] addr0;
        logic [3:0] len0;
        logic [3:0] addr1;
        logic [3:0] len1;
        logic       ready;
        logic [1:0] expAck;
        logic       expValid;
        logic [7:0] expData;
        logic       expId;
        logic       expLast;
        logic       expBusy;
    } vec_t;

    vec_t vecs [13];

    rom_burst_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .addr0    (addr0),
        .addr1    (addr1),
        .len0     (len0),
        .len1     (len1),
        .ack      (ack),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .rd_id    (rd_id),
        .rd_last  (rd_last),
        .busy     (busy)
    );

    assign rom_data = rom[rom_addr];

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record accepted beats and every ack pulse as seen at the clock edge.
    always @(posedge clk) begin
        if (rd_valid && rd_ready) begin
            beatData.push_back(rd_data);
            beatId.push_back(rd_id);
        end
        if (ack != 2'b00) begin
            ackSeq.push_back(ack);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        rst      = v.rst;
        req      = v.req;
        addr0    = v.addr0;
        len0     = v.len0;
        addr1    = v.addr1;
        len1     = v.len1;
        rd_ready = v.ready;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkBeat(input string name, input logic [1:0] a, input logic v,
                             input logic [7:0] d, input logic l, input logic b);
        checkOutput({name, "_ack"},   32'(ack),      32'(a));
        checkOutput({name, "_valid"}, 32'(rd_valid), 32'(v));
        checkOutput({name, "_data"},  32'(rd_data),  32'(d));
        checkOutput({name, "_last"},  32'(rd_last),  32'(l));
        checkOutput({name, "_busy"},  32'(busy),     32'(b));
    endtask

    initial begin
        checks = 0;
        errors = 0;

        for (int i = 0; i < 16; i++) begin
            rom[i] = 8'(8'h10 + i);
        end
        rom[0]  = 8'h1C;
        rom[1]  = 8'h66;
        rom[2]  = 8'hAA;
        rom[3]  = 8'h55;
        rom[14] = 8'h88;
        rom[15] = 8'h44;

        // Inputs applied before an edge; expected outputs just after it.
        //            rst   req    a0    l0    a1     l1    rdy   ack    vld   data    id    last  busy
        vecs[0]  = '{1'b1, 2'b11, 4'd0, 4'd3, 4'd14, 4'd2, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 2'b11, 4'd0, 4'd3, 4'd14, 4'd2, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 2'b01, 4'd0, 4'd3, 4'd14, 4'd2, 1'b1, 2'b01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 2'b00, 4'd0, 4'd3, 4'd14, 4'd2, 1'b1, 2'b00, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 2'b00, 4'd0, 4'd3, 4'd14, 4'd2, 1'b1, 2'b00, 1'b1, 8'h66, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 2'b00, 4'd0, 4'd3, 4'd14, 4'd2, 1'b1, 2'b00, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 2'b00, 4'd0, 4'd3, 4'd14, 4'd2, 1'b1, 2'b00, 1'b1, 8'h55, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 2'b00, 4'd0, 4'd3, 4'd14, 4'd2, 1'b1, 2'b00, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 2'b10, 4'd0, 4'd3, 4'd14, 4'd2, 1'b1, 2'b10, 1'b0, 8'h55, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 2'b00, 4'd7, 4'd9, 4'd5,  4'd7, 1'b1, 2'b00, 1'b1, 8'h88, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 2'b00, 4'd7, 4'd9, 4'd5,  4'd7, 1'b1, 2'b00, 1'b1, 8'h44, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 2'b00, 4'd7, 4'd9, 4'd5,  4'd7, 1'b1, 2'b00, 1'b1, 8'h1C, 1'b1, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 2'b00, 4'd7, 4'd9, 4'd5,  4'd7, 1'b1, 2'b00, 1'b0, 8'h1C, 1'b1, 1'b0, 1'b0};

        applyStimulus(vecs[0]);
        #1;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
            step();
            checkOutput($sformatf("v%0d_ack", i),   32'(ack),      32'(vecs[i].expAck));
            checkOutput($sformatf("v%0d_valid", i), 32'(rd_valid), 32'(vecs[i].expValid));
            checkOutput($sformatf("v%0d_data", i),  32'(rd_data),  32'(vecs[i].expData));
            checkOutput($sformatf("v%0d_id", i),    32'(rd_id),    32'(vecs[i].expId));
            checkOutput($sformatf("v%0d_last", i),  32'(rd_last),  32'(vecs[i].expLast));
            checkOutput($sformatf("v%0d_busy", i),  32'(busy),     32'(vecs[i].expBusy));
        end

        // Backpressure: two-word burst from address 1, consumer stalls on the first word.
        beatData.delete();
        beatId.delete();
        rd_ready = 1'b0;
        req      = 2'b01;
        addr0    = 4'd1;
        len0     = 4'd1;
        step();
        checkBeat("bp_grant", 2'b01, 1'b0, 8'h1C, 1'b0, 1'b1);
        req = 2'b00;
        step();
        checkBeat("bp_first", 2'b00, 1'b1, 8'h66, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            checkBeat($sformatf("bp_stall%0d", i), 2'b00, 1'b1, 8'h66, 1'b0, 1'b1);
        end
        rd_ready = 1'b1;
        step();
        checkBeat("bp_second", 2'b00, 1'b1, 8'hAA, 1'b1, 1'b1);
        step();
        checkBeat("bp_done", 2'b00, 1'b0, 8'hAA, 1'b0, 1'b0);
        checkOutput("bp_beat_count", 32'(beatData.size()), 32'd2);
        if (beatData.size() == 2) begin
            checkOutput("bp_beat0", 32'(beatData[0]), 32'h66);
            checkOutput("bp_beat1", 32'(beatData[1]), 32'hAA);
        end

        // Fairness: both requesters asking continuously with single-word bursts.
        rst   = 1'b1;
        req   = 2'b11;
        step();
        rst   = 1'b0;
        addr0 = 4'd0;
        len0  = 4'd0;
        addr1 = 4'd3;
        len1  = 4'd0;
        beatData.delete();
        beatId.delete();
        ackSeq.delete();
        for (int i = 0; i < 13; i++) begin
            step();
            checkOutput($sformatf("fair_ack_excl%0d", i), 32'(ack == 2'b11), 32'd0);
        end
        checkOutput("fair_ack_count",  32'(ackSeq.size() >= 4),   32'd1);
        checkOutput("fair_beat_count", 32'(beatData.size() >= 4), 32'd1);
        if (ackSeq.size() >= 4 && beatData.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput($sformatf("fair_ack%0d", i),  32'(ackSeq[i]),   (i % 2 == 0) ? 32'h1 : 32'h2);
                checkOutput($sformatf("fair_id%0d", i),   32'(beatId[i]),   (i % 2 == 0) ? 32'h0 : 32'h1);
                checkOutput($sformatf("fair_data%0d", i), 32'(beatData[i]), (i % 2 == 0) ? 32'h1C : 32'h55);
            end
        end

        // Reset in the middle of a sixteen-word burst.
        rst = 1'b1;
        req = 2'b00;
        step();
        rst   = 1'b0;
        req   = 2'b01;
        addr0 = 4'd0;
        len0  = 4'd15;
        step();
        checkBeat("rm_grant", 2'b01, 1'b0, 8'h00, 1'b0, 1'b1);
        req = 2'b00;
        step();
        step();
        step();
        step();
        checkBeat("rm_beat4", 2'b00, 1'b1, 8'h55, 1'b0, 1'b1);
        rst = 1'b1;
        req = 2'b10;
        step();
        checkBeat("rm_reset", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        checkOutput("rm_req1_only_ack", 32'(ack), 32'h2);
        step();
        checkOutput("rm_req1_beat_id", 32'(rd_id), 32'h1);
        rst = 1'b1;
        req = 2'b11;
        step();
        checkOutput("rm_reset2_valid", 32'(rd_valid), 32'h0);
        rst = 1'b0;
        step();
        checkOutput("rm_both_ack", 32'(ack), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
